// File: rtl/fsk_symbol_modulator.sv
// Binary FSK symbol modulator with slew-limited frequency ramp.
//
// A packet source holds `start` high and presents one bit per symbol on
// `symVal`; the block spends SPS clocks on each symbol and pulses `symDone`
// on the last clock so the source can advance. The instantaneous frequency
// word slews toward F_CENTER +/- F_DEV by at most RAMP_STEP per clock. A
// phase accumulator integrates it, and its MSB is the square-wave carrier.
// When the packet ends, the block flushes back to F_CENTER before going idle.
//
// Ports:
//   clk      clock, rising edge
//   rst      synchronous, active-high reset
//   start    transmit request, held high for the whole packet
//   symVal   current symbol bit (1 = upper tone, 0 = lower tone)
//   symDone  one-clock pulse on the last clock of each symbol
//   busy     high while running or flushing
//   freq     instantaneous frequency word
//   phase    phase accumulator
//   fskOut   carrier, phase MSB
module fsk_symbol_modulator #(
  parameter int unsigned        PHASE_W   = 16,
  parameter int unsigned        SPS       = 8,
  parameter logic [PHASE_W-1:0] F_CENTER  = 16'd4096,
  parameter logic [PHASE_W-1:0] F_DEV     = 16'd512,
  parameter logic [PHASE_W-1:0] RAMP_STEP = 16'd128
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               symVal,
  output logic               symDone,
  output logic               busy,
  output logic [PHASE_W-1:0] freq,
  output logic [PHASE_W-1:0] phase,
  output logic               fskOut
);

  localparam int unsigned        CntW    = (SPS > 1) ? $clog2(SPS) : 1;
  localparam logic [CntW-1:0]    CntLast = CntW'(SPS - 1);
  localparam logic [PHASE_W-1:0] FreqHi  = F_CENTER + F_DEV;
  localparam logic [PHASE_W-1:0] FreqLo  = F_CENTER - F_DEV;
  // One extra bit so the target/freq difference never wraps.
  localparam logic signed [PHASE_W:0] StepS = $signed({1'b0, RAMP_STEP});

  typedef enum logic [1:0] {StIdle, StRun, StFlush} state_e;

  state_e                 state_q, state_d;
  logic [CntW-1:0]        samp_cnt_q, samp_cnt_d;
  logic                   cur_sym_q, cur_sym_d;
  logic [PHASE_W-1:0]     freq_q, freq_d;
  logic [PHASE_W-1:0]     phase_q, phase_d;
  logic [PHASE_W-1:0]     target;
  logic signed [PHASE_W:0] diff;
  logic                   sym_last;

  // Registers only: the symbol boundary never depends on an input.
  assign sym_last = (state_q == StRun) && (samp_cnt_q == CntLast);

  // Sequencing: symVal is sampled only on entry to RUN and at symbol ends.
  always_comb begin
    state_d    = state_q;
    samp_cnt_d = samp_cnt_q;
    cur_sym_d  = cur_sym_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d    = StRun;
          cur_sym_d  = symVal;
          samp_cnt_d = '0;
        end
      end
      StRun: begin
        if (sym_last) begin
          samp_cnt_d = '0;
          cur_sym_d  = symVal;
          // A falling start only takes effect here, so a symbol is never cut short.
          if (!start) begin
            state_d = StFlush;
          end
        end else begin
          samp_cnt_d = samp_cnt_q + CntW'(1);
        end
      end
      StFlush: begin
        if (freq_q == F_CENTER) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Frequency target and slew limiter.
  always_comb begin
    target = F_CENTER;
    if (state_q == StRun) begin
      target = cur_sym_q ? FreqHi : FreqLo;
    end
  end

  assign diff = $signed({1'b0, target}) - $signed({1'b0, freq_q});

  always_comb begin
    freq_d = target;
    if (diff > StepS) begin
      freq_d = freq_q + RAMP_STEP;
    end else if (diff < -StepS) begin
      freq_d = freq_q - RAMP_STEP;
    end
  end

  // Accumulate with the pre-update frequency. The accumulator is cleared on
  // the edge that returns to IDLE, so phase reads 0 whenever the block is idle.
  always_comb begin
    phase_d = '0;
    if ((state_q != StIdle) && (state_d != StIdle)) begin
      phase_d = phase_q + freq_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      samp_cnt_q <= '0;
      cur_sym_q  <= 1'b0;
      freq_q     <= F_CENTER;
      phase_q    <= '0;
    end else begin
      state_q    <= state_d;
      samp_cnt_q <= samp_cnt_d;
      cur_sym_q  <= cur_sym_d;
      freq_q     <= freq_d;
      phase_q    <= phase_d;
    end
  end

  assign symDone = sym_last;
  assign busy    = (state_q != StIdle);
  assign freq    = freq_q;
  assign phase   = phase_q;
  assign fskOut  = phase_q[PHASE_W-1];

endmodule

// File: tb/tb_fsk_symbol_modulator.sv
// Bench for fsk_symbol_modulator: a stimulus process plays the packet source
// and pushes the expected frequency and spacing of every symDone pulse into a
// queue; a monitor process pops and checks an entry on each pulse it sees.
module tb_fsk_symbol_modulator;

  localparam int unsigned PW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          symVal;
  logic          symDone;
  logic          busy;
  logic [PW-1:0] freq;
  logic [PW-1:0] phase;
  logic          fskOut;

  always #5 clk = ~clk;

  fsk_symbol_modulator #(
    .PHASE_W  (16),
    .SPS      (8),
    .F_CENTER (16'd4096),
    .F_DEV    (16'd512),
    .RAMP_STEP(16'd128)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .symVal (symVal),
    .symDone(symDone),
    .busy   (busy),
    .freq   (freq),
    .phase  (phase),
    .fskOut (fskOut)
  );

  typedef struct {
    int unsigned freq;
    int unsigned gap;
  } pulse_t;

  pulse_t exp_q[$];
  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int last_mark = 0;
  int pulses = 0;
  int wraps  = 0;
  logic          busy_prev = 1'b0;
  logic [PW-1:0] phase_prev = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: samples on the falling edge, checks every symDone pulse.
  initial begin : monitor
    pulse_t item;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst) begin
        check("fsk_is_msb", 32'(fskOut), 32'(phase[PW-1]));
        if (busy && !busy_prev) last_mark = cyc;
        if (busy) begin
          check("freq_in_band", 32'((freq >= 16'd3584) && (freq <= 16'd4608)), 32'd1);
          if (busy_prev && (phase < phase_prev)) wraps++;
        end else begin
          check("idle_phase", 32'(phase), 32'd0);
          check("idle_symdone", 32'(symDone), 32'd0);
        end
        if (symDone) begin
          pulses++;
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_symdone at cycle %0d", cyc);
          end else begin
            item = exp_q.pop_front();
            check("symdone_freq", 32'(freq), item.freq);
            check("symdone_gap", 32'(cyc - last_mark), item.gap);
          end
          last_mark = cyc;
        end
      end
      busy_prev  = busy;
      phase_prev = phase;
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

  // Ten-symbol packet and the hand-computed freq on each symDone clock.
  int unsigned sym[10] = '{1, 1, 0, 1, 0, 0, 1, 1, 0, 1};
  int unsigned pf[10]  = '{4608, 4608, 3712, 4480, 3712, 3584, 4480, 4608, 3712, 4480};

  initial begin : stim
    int k;
    rst    = 1'b1;
    start  = 1'b1;
    symVal = 1'b1;
    tick();
    tick();
    // Reset dominates a held start.
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_freq", 32'(freq), 32'd4096);
    check("rst_phase", 32'(phase), 32'd0);
    check("rst_symdone", 32'(symDone), 32'd0);
    check("rst_fsk", 32'(fskOut), 32'd0);

    // Packet 1: ten symbols, garbage on symVal between symbol boundaries.
    k = 0;
    symVal = sym[0][0];
    exp_q.push_back('{pf[0], 7});
    rst = 1'b0;
    for (int n = 0; n <= 85; n++) begin
      tick();
      case (n)
        0: begin
          check("run_busy", 32'(busy), 32'd1);
          check("e0_freq", 32'(freq), 32'd4096);
          check("e0_phase", 32'(phase), 32'd0);
        end
        1: begin
          check("e1_freq", 32'(freq), 32'd4224);
          check("e1_phase", 32'(phase), 32'd4096);
        end
        2: begin
          check("e2_freq", 32'(freq), 32'd4352);
          check("e2_phase", 32'(phase), 32'd8320);
        end
        3: begin
          check("e3_freq", 32'(freq), 32'd4480);
          check("e3_phase", 32'(phase), 32'd12672);
        end
        4: begin
          check("e4_freq", 32'(freq), 32'd4608);
          check("e4_phase", 32'(phase), 32'd17152);
        end
        5: begin
          check("e5_freq_hold", 32'(freq), 32'd4608);
          check("e5_phase", 32'(phase), 32'd21760);
        end
        14: begin
          check("e14_phase", 32'(phase), 32'd63232);
          check("e14_fsk", 32'(fskOut), 32'd1);
        end
        15: begin
          check("e15_phase_wrap", 32'(phase), 32'd2304);
          check("e15_fsk", 32'(fskOut), 32'd0);
        end
        80: begin
          check("flush_busy", 32'(busy), 32'd1);
          check("flush_freq0", 32'(freq), 32'd4608);
        end
        82: check("flush_freq2", 32'(freq), 32'd4352);
        84: begin
          check("flush_center_busy", 32'(busy), 32'd1);
          check("flush_center_freq", 32'(freq), 32'd4096);
        end
        85: begin
          check("end_busy", 32'(busy), 32'd0);
          check("end_freq", 32'(freq), 32'd4096);
          check("end_phase", 32'(phase), 32'd0);
        end
        default: ;
      endcase
      if (symDone) begin
        k++;
        if (k < 10) begin
          symVal = sym[k][0];
          exp_q.push_back('{pf[k], 8});
        end else begin
          start = 1'b0;
        end
      end else if (k < 10) begin
        symVal = ~sym[k][0];
      end
    end

    // Packet 2: start drops at samp_cnt=3; the symbol still runs to the end.
    start  = 1'b1;
    symVal = 1'b0;
    exp_q.push_back('{3584, 7});
    for (int n = 0; n <= 15; n++) begin
      tick();
      case (n)
        3: start = 1'b0;
        4: symVal = 1'b1;
        8: begin
          check("drop_flush_busy", 32'(busy), 32'd1);
          check("drop_flush_freq", 32'(freq), 32'd3584);
        end
        12: begin
          check("drop_center_busy", 32'(busy), 32'd1);
          check("drop_center_freq", 32'(freq), 32'd4096);
        end
        13: begin
          check("drop_idle_busy", 32'(busy), 32'd0);
          check("drop_idle_phase", 32'(phase), 32'd0);
        end
        15: check("drop_stay_idle", 32'(busy), 32'd0);
        default: ;
      endcase
    end

    // Packet 3: reset at samp_cnt=5, no symDone may appear.
    start  = 1'b1;
    symVal = 1'b1;
    for (int n = 0; n <= 5; n++) tick();
    check("pre_rst_freq", 32'(freq), 32'd4608);
    check("pre_rst_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    tick();
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_freq", 32'(freq), 32'd4096);
    check("mid_rst_phase", 32'(phase), 32'd0);
    check("mid_rst_symdone", 32'(symDone), 32'd0);
    check("mid_rst_fsk", 32'(fskOut), 32'd0);
    rst   = 1'b0;
    start = 1'b0;
    tick();
    tick();
    check("post_rst_busy", 32'(busy), 32'd0);

    check("pulse_count", 32'(pulses), 32'd11);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    check("phase_wrapped", 32'(wraps > 0), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
